// File: rtl/dsram_bridge.sv
// rtl/dsram_bridge.sv - memory-stage SRAM request to req/addr_ok/data_ok bridge with flush cancel
// Optional data_ok watchdog enabled by defining DSRAM_TIMEOUT_EN.
module dsram_bridge #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ms_valid,
  input  logic        ms_mem_en,
  input  logic        ms_advance,
  input  logic        flush,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        ms_stall,
  output logic [31:0] ms_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wen_q;
  logic        mem_pending, is_store, start, capture, timeout, tmo_fire;
  logic [1:0]  store_size;

  assign mem_pending = ms_valid & ms_mem_en;
  assign is_store    = |wen_q;
  assign tmo_fire    = timeout & ~data_data_ok;

`ifdef DSRAM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] cnt;
  logic             bus_err_q;

  assign timeout = ((state == WAIT) || (state == CANCEL)) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;

  // Counter restarts on every state change so WAIT and CANCEL each get a full window
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt       <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= tmo_fire;
      if (state_next != state)
        cnt <= '0;
      else if ((state == WAIT) || (state == CANCEL))
        cnt <= cnt + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign bus_err            = 1'b0;
`endif

  always_comb begin
    state_next = state;
    start      = 1'b0;
    capture    = 1'b0;
    ms_stall   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_pending && !flush) begin
          start      = 1'b1;
          ms_stall   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        ms_stall = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok && flush) begin
            state_next = IDLE;
          end else if (data_data_ok) begin
            capture    = ~is_store;
            state_next = DONE;
          end else if (flush) begin
            state_next = CANCEL;
          end else begin
            state_next = WAIT;
          end
        end else if (flush) begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        ms_stall = 1'b1;
        if (data_data_ok && flush) begin
          state_next = IDLE;
        end else if (data_data_ok) begin
          capture    = ~is_store;
          state_next = DONE;
        end else if (tmo_fire) begin
          state_next = IDLE;
        end else if (flush) begin
          state_next = CANCEL;
        end
      end
      DONE: begin
        if (ms_advance || flush)
          state_next = IDLE;
      end
      CANCEL: begin
        // Hold off the next memory instruction until the orphaned response drains
        ms_stall = mem_pending;
        if (data_data_ok || tmo_fire)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      addr_q  <= '0;
      wen_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        addr_q  <= data_sram_addr;
        wen_q   <= data_sram_wen;
        wdata_q <= data_sram_wdata;
      end
      if (capture)
        rdata_q <= data_rdata;
    end
  end

  always_comb begin
    case (wen_q)
      4'b1111:          store_size = 2'd2;
      4'b0011, 4'b1100: store_size = 2'd1;
      default:          store_size = 2'd0;
    endcase
  end

  // Request fields come only from the latched copies, so they cannot move while REQ waits on addr_ok
  always_comb begin
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd0;
    data_addr  = '0;
    data_wstrb = '0;
    data_wdata = '0;
    if (state == REQ) begin
      data_req = 1'b1;
      if (is_store) begin
        data_wr    = 1'b1;
        data_size  = store_size;
        data_addr  = addr_q;
        data_wstrb = wen_q;
        data_wdata = wdata_q;
      end else begin
        data_size = 2'd2;
        data_addr = {addr_q[31:2], 2'b00};
      end
    end
  end

  assign ms_rdata = rdata_q;

endmodule

// File: tb/tb_dsram_bridge.sv
// tb/tb_dsram_bridge.sv - directed scoreboard bench for dsram_bridge
// Watchdog steps run only when DSRAM_TIMEOUT_EN is defined.
module tb_dsram_bridge;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ms_valid, ms_mem_en, ms_advance, flush;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        ms_stall;
  logic [31:0] ms_rdata;
  logic        bus_err;

  req_t        exp_req[$];
  logic [31:0] exp_rd[$];
  int          checks = 0;
  int          errors = 0;

  logic [3:0]  st_wen  [3] = '{4'b0100, 4'b1100, 4'b1111};
  logic [31:0] st_addr [3] = '{32'h0000_2002, 32'h0000_2102, 32'h0000_2200};
  logic [31:0] st_wdata[3] = '{32'h5A5A_5A5A, 32'h1234_1234, 32'h8765_4321};
  logic [1:0]  st_size [3] = '{2'd0, 2'd1, 2'd2};

  always #5 clk = ~clk;

  dsram_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .ms_valid        (ms_valid),
    .ms_mem_en       (ms_mem_en),
    .ms_advance      (ms_advance),
    .flush           (flush),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wstrb      (data_wstrb),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .ms_stall        (ms_stall),
    .ms_rdata        (ms_rdata),
    .bus_err         (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] addr);
    req_t r;
    ms_valid = 1'b1; ms_mem_en = 1'b1;
    data_sram_wen = 4'b0000; data_sram_addr = addr; data_sram_wdata = 32'h0;
    r.wr = 1'b0; r.size = 2'd2; r.addr = {addr[31:2], 2'b00}; r.wstrb = 4'b0; r.wdata = 32'h0;
    exp_req.push_back(r);
  endtask

  task automatic store(input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size);
    req_t r;
    ms_valid = 1'b1; ms_mem_en = 1'b1;
    data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wdata;
    r.wr = 1'b1; r.size = size; r.addr = addr; r.wstrb = wen; r.wdata = wdata;
    exp_req.push_back(r);
  endtask

  task automatic idle();
    ms_valid = 1'b0; ms_mem_en = 1'b0; data_sram_wen = 4'b0;
  endtask

  task automatic check_req(input string tag);
    req_t r;
    chk({tag, "_req"}, data_req, 1'b1);
    chk({tag, "_sb_req_pending"}, 32'(exp_req.size() != 0), 32'd1);
    if (exp_req.size() != 0) begin
      r = exp_req.pop_front();
      chk({tag, "_wr"},    data_wr,    r.wr);
      chk({tag, "_size"},  data_size,  r.size);
      chk({tag, "_addr"},  data_addr,  r.addr);
      chk({tag, "_wstrb"}, data_wstrb, r.wstrb);
      chk({tag, "_wdata"}, data_wdata, r.wdata);
    end
  endtask

  task automatic check_rd(input string tag);
    chk({tag, "_sb_rd_pending"}, 32'(exp_rd.size() != 0), 32'd1);
    if (exp_rd.size() != 0)
      chk({tag, "_rdata"}, ms_rdata, exp_rd.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn = 1'b0; ms_advance = 1'b0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", data_req, 1'b0);
    chk("rst_stall", ms_stall, 1'b0);
    chk("rst_rdata", ms_rdata, 32'h0);
    chk("rst_addr", data_addr, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(negedge clk); resetn = 1'b1;

    // Word load with delayed addr_ok and data_ok
    @(negedge clk); load(32'h0000_1004); #1;
    chk("t1_idle_stall", ms_stall, 1'b1);
    chk("t1_idle_noreq", data_req, 1'b0);
    @(negedge clk); #1;
    check_req("t1");
    chk("t1_req_stall", ms_stall, 1'b1);
    @(negedge clk); data_addr_ok = 1'b1; #1;
    chk("t1_req_held", data_req, 1'b1);
    chk("t1_addr_stable", data_addr, 32'h0000_1004);
    @(negedge clk); data_addr_ok = 1'b0; #1;
    chk("t1_wait_noreq", data_req, 1'b0);
    chk("t1_wait_stall", ms_stall, 1'b1);
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; exp_rd.push_back(32'hDEAD_BEEF); #1;
    chk("t1_dok_stall", ms_stall, 1'b1);
    @(negedge clk); data_data_ok = 1'b0; data_rdata = 32'hFFFF_0000; #1;
    chk("t1_done_stall", ms_stall, 1'b0);
    check_rd("t1");
    @(negedge clk); ms_advance = 1'b1; #1;
    chk("t1_done_hold", ms_rdata, 32'hDEAD_BEEF);
    @(negedge clk); ms_advance = 1'b0; idle(); #1;
    chk("t1_idle_stall_rel", ms_stall, 1'b0);
    chk("t1_idle_req", data_req, 1'b0);

    // Stores of each width, addr_ok and data_ok together
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); store(st_wen[i], st_addr[i], st_wdata[i], st_size[i]); #1;
      chk($sformatf("st%0d_idle_stall", i), ms_stall, 1'b1);
      @(negedge clk); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h0BAD_0BAD; #1;
      check_req($sformatf("st%0d", i));
      chk($sformatf("st%0d_req_stall", i), ms_stall, 1'b1);
      @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
      chk($sformatf("st%0d_done_stall", i), ms_stall, 1'b0);
      chk($sformatf("st%0d_done_noreq", i), data_req, 1'b0);
      chk($sformatf("st%0d_rdata_kept", i), ms_rdata, 32'hDEAD_BEEF);
      ms_advance = 1'b1;
      @(negedge clk); ms_advance = 1'b0; idle();
    end

    // Flush in REQ before addr_ok withdraws the request
    @(negedge clk); load(32'h0000_3000);
    @(negedge clk); flush = 1'b1; #1;
    check_req("t3");
    @(negedge clk); flush = 1'b0; idle(); #1;
    chk("t3_req_drop", data_req, 1'b0);
    chk("t3_stall", ms_stall, 1'b0);
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h7777_7777; #1;
    chk("t3_idle_dok_stall", ms_stall, 1'b0);
    @(negedge clk); data_data_ok = 1'b0; #1;
    chk("t3_rdata_kept", ms_rdata, 32'hDEAD_BEEF);
    chk("t3_idle_req", data_req, 1'b0);

    // Flush in WAIT; response drained by CANCEL while a new load waits
    @(negedge clk); load(32'h0000_4000);
    @(negedge clk); data_addr_ok = 1'b1; #1;
    check_req("t4a");
    @(negedge clk); data_addr_ok = 1'b0; flush = 1'b1; #1;
    chk("t4_wait_stall", ms_stall, 1'b1);
    @(negedge clk); flush = 1'b0; load(32'h0000_4100); #1;
    chk("t4_cancel_noreq", data_req, 1'b0);
    chk("t4_cancel_stall", ms_stall, 1'b1);
    @(negedge clk); #1;
    chk("t4_cancel_noreq2", data_req, 1'b0);
    chk("t4_cancel_stall2", ms_stall, 1'b1);
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h1234_5678; #1;
    chk("t4_cancel_dok_noreq", data_req, 1'b0);
    @(negedge clk); data_data_ok = 1'b0; #1;
    chk("t4_idle_noreq", data_req, 1'b0);
    chk("t4_idle_stall", ms_stall, 1'b1);
    chk("t4_rdata_kept", ms_rdata, 32'hDEAD_BEEF);
    @(negedge clk); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
    exp_rd.push_back(32'hCAFE_F00D); #1;
    check_req("t4b");
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b0; #1;
    check_rd("t4b");
    chk("t4_done_stall", ms_stall, 1'b0);
    ms_advance = 1'b1;
    @(negedge clk); ms_advance = 1'b0; idle();

    // Back-to-back loads
    @(negedge clk); load(32'h0000_0010);
    @(negedge clk); data_addr_ok = 1'b1; #1;
    check_req("t5a");
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hA0A0_0010;
    exp_rd.push_back(32'hA0A0_0010); #1;
    chk("t5a_wait_stall", ms_stall, 1'b1);
    @(negedge clk); data_data_ok = 1'b0; ms_advance = 1'b1; #1;
    check_rd("t5a");
    chk("t5a_done_stall", ms_stall, 1'b0);
    @(negedge clk); ms_advance = 1'b0; load(32'h0000_0014); #1;
    chk("t5_gap_noreq", data_req, 1'b0);
    chk("t5_gap_stall", ms_stall, 1'b1);
    @(negedge clk); data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hB0B0_0014;
    exp_rd.push_back(32'hB0B0_0014); #1;
    check_req("t5b");
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b0; ms_advance = 1'b1; #1;
    check_rd("t5b");
    chk("t5b_done_stall", ms_stall, 1'b0);
    @(negedge clk); ms_advance = 1'b0; idle(); #1;
    chk("t5_end_noreq", data_req, 1'b0);

`ifdef DSRAM_TIMEOUT_EN
    // Watchdog: four WAIT cycles without data_ok
    @(negedge clk); load(32'h0000_0020);
    @(negedge clk); data_addr_ok = 1'b1; #1;
    check_req("tmo");
    @(negedge clk); data_addr_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tmo_wait%0d_err", i), bus_err, 1'b0);
      chk($sformatf("tmo_wait%0d_stall", i), ms_stall, 1'b1);
      @(negedge clk);
    end
    idle(); #1;
    chk("tmo_bus_err", bus_err, 1'b1);
    chk("tmo_stall_rel", ms_stall, 1'b0);
    chk("tmo_noreq", data_req, 1'b0);
    @(negedge clk); #1;
    chk("tmo_err_pulse", bus_err, 1'b0);
`endif

    chk("sb_req_drained", 32'(exp_req.size()), 32'd0);
    chk("sb_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
